// File: rtl/piso_pkg.sv
// Shared types and defaults for the piso_tx serialiser.
// Optional feature macro: PISO_PARITY_EN (adds an even-parity bit after each word).
package piso_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} piso_state_t;

  localparam int unsigned PISO_N = 8;

endpackage

// File: rtl/piso_bitcnt.sv
// Modulo-N bit counter: tracks which serial bit of the word is on the wire.
module piso_bitcnt
  import piso_pkg::*;
#(
  parameter int unsigned N = PISO_N
) (
  input  logic clk,
  input  logic n_reset,
  input  logic clr,
  input  logic inc,
  output logic at_last
);

  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  logic [CntW-1:0] cnt_q;

  // Count register: clear wins over increment, wraps after the final bit.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= at_last ? '0 : cnt_q + CntW'(1);
    end
  end

  // Final-bit flag decoded straight from the register.
  always_comb begin
    at_last = (cnt_q == CntW'(N - 1));
  end

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with valid/ready load and frame/last qualifiers.
// Optional feature macro: PISO_PARITY_EN (one even-parity bit follows the data bits).
module piso_tx
  import piso_pkg::*;
#(
  parameter int unsigned N         = PISO_N,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic [N-1:0] din,
  input  logic         load_valid,
  output logic         load_ready,
  output logic         sout,
  output logic         frame,
  output logic         last
);

  piso_state_t  state_q, state_d;
  logic [N-1:0] sreg_q, sreg_d;
  logic         at_last;
  logic         accept;

  assign accept = load_valid & load_ready;

  piso_bitcnt #(
    .N (N)
  ) u_bitcnt (
    .clk     (clk),
    .n_reset (n_reset),
    .clr     (accept),
    .inc     (state_q == SHIFT),
    .at_last (at_last)
  );

`ifdef PISO_PARITY_EN
  logic par_q;

  // Even parity of the word, captured together with the word.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      par_q <= 1'b0;
    end else if (accept) begin
      par_q <= ^din;
    end
  end
`endif

  // State and shift register.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= IDLE;
      sreg_q  <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
    end
  end

  // Next state: reload on the final cycle keeps back-to-back words gap-free.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = SHIFT;
      end
      SHIFT: begin
        if (at_last) begin
`ifdef PISO_PARITY_EN
          state_d = PARITY;
`else
          state_d = accept ? SHIFT : IDLE;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        state_d = accept ? SHIFT : IDLE;
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Shift register: load on accept, otherwise shift with zero fill while sending.
  always_comb begin
    sreg_d = sreg_q;
    if (accept) begin
      sreg_d = din;
    end else if (state_q == SHIFT) begin
      sreg_d = MSB_FIRST ? (sreg_q << 1) : (sreg_q >> 1);
    end
  end

  // Outputs decoded only from registered state so sout/frame are glitch-free.
  always_comb begin
    load_ready = 1'b0;
    sout       = 1'b0;
    frame      = 1'b0;
    last       = 1'b0;
    unique case (state_q)
      IDLE: begin
        load_ready = 1'b1;
      end
      SHIFT: begin
        frame = 1'b1;
        sout  = MSB_FIRST ? sreg_q[N-1] : sreg_q[0];
`ifndef PISO_PARITY_EN
        last       = at_last;
        load_ready = at_last;
`endif
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        frame      = 1'b1;
        sout       = par_q;
        last       = 1'b1;
        load_ready = 1'b1;
      end
`endif
      default: begin
        load_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: one MSB-first and one LSB-first instance share all stimulus.
module tb_piso_tx;

  logic       clk;
  logic       n_reset;
  logic [7:0] din;
  logic       load_valid;
  logic       rdy_m, sout_m, frame_m, last_m;
  logic       rdy_l, sout_l, frame_l, last_l;
  logic [7:0] cap;

  int n_vec = 0;
  int n_err = 0;

  piso_tx #(
    .N         (8),
    .MSB_FIRST (1'b1)
  ) u_dut_msb (
    .clk        (clk),
    .n_reset    (n_reset),
    .din        (din),
    .load_valid (load_valid),
    .load_ready (rdy_m),
    .sout       (sout_m),
    .frame      (frame_m),
    .last       (last_m)
  );

  piso_tx #(
    .N         (8),
    .MSB_FIRST (1'b0)
  ) u_dut_lsb (
    .clk        (clk),
    .n_reset    (n_reset),
    .din        (din),
    .load_valid (load_valid),
    .load_ready (rdy_l),
    .sout       (sout_l),
    .frame      (frame_l),
    .last       (last_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream deserialiser stand-in: MSB-first shift-in while frame is high.
  always @(posedge clk) begin
    if (frame_m) cap <= {cap[6:0], sout_m};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called once the word is on its way in (load_valid/din set before the accepting edge).
  // exp_m/exp_l list the expected bits in wire order from bit 7 down to bit 0.
  task automatic xmit(input string tag, input logic [7:0] exp_m, input logic [7:0] exp_l,
                      input logic par, input bit chain, input logic [7:0] nxt);
    bit fin;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
`ifdef PISO_PARITY_EN
      fin = 1'b0;
`else
      fin = (i == 7);
`endif
      check({tag, ".sout_m"}, 32'(sout_m), 32'(exp_m[7-i]));
      check({tag, ".sout_l"}, 32'(sout_l), 32'(exp_l[7-i]));
      check({tag, ".frame"}, {30'd0, frame_m, frame_l}, 32'h3);
      check({tag, ".last"}, {30'd0, last_m, last_l}, fin ? 32'h3 : 32'h0);
      check({tag, ".ready"}, {30'd0, rdy_m, rdy_l}, fin ? 32'h3 : 32'h0);
      // Junk on din while not ready must be ignored.
      din        = fin ? nxt : 8'h5A;
      load_valid = fin ? chain : 1'b1;
    end
`ifdef PISO_PARITY_EN
    @(negedge clk);
    check({tag, ".par_m"}, 32'(sout_m), 32'(par));
    check({tag, ".par_l"}, 32'(sout_l), 32'(par));
    check({tag, ".par_last"}, {30'd0, last_m, last_l}, 32'h3);
    check({tag, ".par_ready"}, {30'd0, rdy_m, rdy_l}, 32'h3);
    din        = nxt;
    load_valid = chain;
`else
    if (par) begin end
`endif
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    check({tag, ".idle_frame"}, {30'd0, frame_m, frame_l}, 32'h0);
    check({tag, ".idle_last"}, {30'd0, last_m, last_l}, 32'h0);
    check({tag, ".idle_sout"}, {30'd0, sout_m, sout_l}, 32'h0);
    check({tag, ".idle_ready"}, {30'd0, rdy_m, rdy_l}, 32'h3);
  endtask

  initial begin
    n_reset    = 1'b0;
    din        = 8'h00;
    load_valid = 1'b0;
    cap        = 8'h00;

    // Reset held for three cycles.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.sout", {30'd0, sout_m, sout_l}, 32'h0);
    check("rst.frame", {30'd0, frame_m, frame_l}, 32'h0);
    check("rst.last", {30'd0, last_m, last_l}, 32'h0);
    n_reset = 1'b1;
    @(negedge clk);
    check("rst.ready", {30'd0, rdy_m, rdy_l}, 32'h3);

    // Single word B4.
    din        = 8'hB4;
    load_valid = 1'b1;
    xmit("b4", 8'hB4, 8'h2D, 1'b0, 1'b0, 8'h00);
`ifndef PISO_PARITY_EN
    check_idle("b4");
    check("b4.sipo", 32'(cap), 32'hB4);
`else
    check_idle("b4");
`endif

    // Back-to-back A5 then 3C with load_valid held.
    din        = 8'hA5;
    load_valid = 1'b1;
    xmit("a5", 8'hA5, 8'hA5, 1'b0, 1'b1, 8'h3C);
    xmit("3c", 8'h3C, 8'h3C, 1'b0, 1'b0, 8'h00);
    check_idle("3c");

    // 01: LSB-first instance sends the 1 first.
    din        = 8'h01;
    load_valid = 1'b1;
    xmit("01", 8'h01, 8'h80, 1'b1, 1'b0, 8'h00);
    check_idle("01");

    // 07: odd weight, parity bit 1 when enabled.
    din        = 8'h07;
    load_valid = 1'b1;
    xmit("07", 8'h07, 8'hE0, 1'b1, 1'b0, 8'h00);
    check_idle("07");

    // Reset mid-word after three bits of FF.
    din        = 8'hFF;
    load_valid = 1'b1;
    @(posedge clk);
    #1 load_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("ff.sout", {30'd0, sout_m, sout_l}, 32'h3);
    n_reset = 1'b0;
    #1;
    check("ff.abort_sout", {30'd0, sout_m, sout_l}, 32'h0);
    check("ff.abort_frame", {30'd0, frame_m, frame_l}, 32'h0);
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);
    check("ff.ready", {30'd0, rdy_m, rdy_l}, 32'h3);
    din        = 8'h81;
    load_valid = 1'b1;
    xmit("81", 8'h81, 8'h81, 1'b0, 1'b0, 8'h00);
    check_idle("81");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
